// File: rtl/i2c_pad_frontend.sv
// i2c_pad_frontend
// Sits between the I2C master's SCL/SDA level/direction outputs and the
// board's open-drain pads. Turns the master's requests into open-drain
// tristate controls. Synchronises and glitch-filters the returned pad
// levels, and hands the filtered SDA back to the master. Also monitors the
// bus: START/STOP detection, bus-busy, clock-stretch and sticky
// arbitration-lost.
//
// Parameters
//   FILTER_LEN   : identical synchronised samples needed to accept a new level (1..15)
//   IDLE_TIMEOUT : cycles with both filtered lines high before busy is force-cleared
//
// Ports
//   i_clk, i_rst             : system clock, async active-high reset
//   i_scl, i_sda, i_sda_dir  : master requests (1 = release; dir 1 = input)
//   i_clr_arb                : clears sticky arbitration-lost
//   o_scl_t, o_sda_t         : pad tristate controls (1 = hi-Z, 0 = drive low)
//   i_scl_pad, i_sda_pad     : raw pad levels
//   o_scl_filt, o_sda_filt   : filtered pad levels
//   o_start_det, o_stop_det  : single-cycle START / STOP pulses
//   o_busy, o_stretch        : bus busy, slave holding SCL low
//   o_arb_lost               : sticky, released-high SDA seen low at SCL rise
module i2c_pad_frontend #(
  parameter int FILTER_LEN   = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  input  logic i_sda_dir,
  input  logic i_clr_arb,
  output logic o_scl_t,
  output logic o_sda_t,
  input  logic i_scl_pad,
  input  logic i_sda_pad,
  output logic o_scl_filt,
  output logic o_sda_filt,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_busy,
  output logic o_stretch,
  output logic o_arb_lost
);

  localparam logic [3:0]  FILT_LAST   = 4'(FILTER_LEN - 1);
  localparam logic [15:0] IDLE_MAX    = 16'(IDLE_TIMEOUT);
  localparam logic [4:0]  STRETCH_THR = 5'(FILTER_LEN + 3);
  localparam logic [4:0]  REL_MAX     = 5'd31;

  logic scl_t, sda_t;
  logic sda_drive_high;
  logic scl_s1, scl_s2, sda_s1, sda_s2;
  logic [3:0] scl_cnt, sda_cnt;
  logic scl_f, sda_f;
  logic scl_prev, sda_prev;
  logic [15:0] idle_cnt;
  logic [4:0] rel_cnt;
  logic busy, arb_lost;

  logic start_det, stop_det, filt_edge, idle_timeout, scl_rise, both_high;

  // Pad drive. Reset releases both pads immediately via the async reset.
  // sda_drive_high remembers that the master was actively outputting a 1,
  // which is the only case where a low SDA means someone else won the bus.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_t          <= 1'b1;
      sda_t          <= 1'b1;
      sda_drive_high <= 1'b0;
    end else begin
      scl_t          <= i_scl;
      sda_t          <= i_sda_dir | i_sda;
      sda_drive_high <= ~i_sda_dir & i_sda;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= i_scl_pad;
      scl_s2 <= scl_s1;
      sda_s1 <= i_sda_pad;
      sda_s2 <= sda_s1;
    end
  end

  // Glitch filters: a new level is accepted on the FILTER_LEN-th consecutive
  // differing sample; any agreeing sample restarts the run.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_f   <= 1'b1;
      scl_cnt <= 4'd0;
    end else if (scl_s2 != scl_f) begin
      if (scl_cnt == FILT_LAST) begin
        scl_f   <= scl_s2;
        scl_cnt <= 4'd0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end
    end else begin
      scl_cnt <= 4'd0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sda_f   <= 1'b1;
      sda_cnt <= 4'd0;
    end else if (sda_s2 != sda_f) begin
      if (sda_cnt == FILT_LAST) begin
        sda_f   <= sda_s2;
        sda_cnt <= 4'd0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
    end else begin
      sda_cnt <= 4'd0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  // SCL must be high in both cycles, so a simultaneous SCL/SDA change is
  // never reported as START or STOP.
  assign start_det    = scl_prev & scl_f &  sda_prev & ~sda_f;
  assign stop_det     = scl_prev & scl_f & ~sda_prev &  sda_f;
  assign scl_rise     = ~scl_prev & scl_f;
  assign filt_edge    = (scl_prev ^ scl_f) | (sda_prev ^ sda_f);
  assign both_high    = scl_f & sda_f;
  assign idle_timeout = (idle_cnt == IDLE_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idle_cnt <= 16'd0;
    end else if (filt_edge || !both_high) begin
      idle_cnt <= 16'd0;
    end else if (!idle_timeout) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  // START has priority so a (repeated) START coinciding with the timeout
  // leaves the bus marked busy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy <= 1'b0;
    end else if (start_det) begin
      busy <= 1'b1;
    end else if (stop_det || idle_timeout) begin
      busy <= 1'b0;
    end
  end

  // Counts cycles that SCL stays low after we released it. The threshold
  // allows for our own sync + filter latency before a stretch is declared.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rel_cnt <= 5'd0;
    end else if (!scl_t || scl_f) begin
      rel_cnt <= 5'd0;
    end else if (rel_cnt != REL_MAX) begin
      rel_cnt <= rel_cnt + 5'd1;
    end
  end

  // Set wins over clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      arb_lost <= 1'b0;
    end else if (scl_rise && sda_drive_high && !sda_f && busy) begin
      arb_lost <= 1'b1;
    end else if (i_clr_arb) begin
      arb_lost <= 1'b0;
    end
  end

  assign o_scl_t     = scl_t;
  assign o_sda_t     = sda_t;
  assign o_scl_filt  = scl_f;
  assign o_sda_filt  = sda_f;
  assign o_start_det = start_det;
  assign o_stop_det  = stop_det;
  assign o_busy      = busy;
  // Masked by the filtered level so the flag drops as soon as SCL is seen high.
  assign o_stretch   = (rel_cnt > STRETCH_THR) & ~scl_f;
  assign o_arb_lost  = arb_lost;

endmodule

// File: tb/tb_i2c_pad_frontend.sv
// Testbench for i2c_pad_frontend: directed bus scenarios plus a randomized
// phase, every cycle compared against a behavioural model of the bus rules.
module tb_i2c_pad_frontend;

  localparam int FL = 4;
  localparam int IT = 1024;

  logic i_clk = 1'b0;
  logic i_rst, i_scl, i_sda, i_sda_dir, i_clr_arb;
  logic o_scl_t, o_sda_t, o_scl_filt, o_sda_filt;
  logic o_start_det, o_stop_det, o_busy, o_stretch, o_arb_lost;
  logic i_scl_pad, i_sda_pad;
  logic ext_scl, ext_sda;   // external open-drain pull-downs on the pads

  int checks = 0;
  int failures = 0;

  assign i_scl_pad = o_scl_t & ~ext_scl;
  assign i_sda_pad = o_sda_t & ~ext_sda;

  always #5 i_clk = ~i_clk;

  i2c_pad_frontend #(.FILTER_LEN(FL), .IDLE_TIMEOUT(IT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_scl(i_scl), .i_sda(i_sda), .i_sda_dir(i_sda_dir), .i_clr_arb(i_clr_arb),
    .o_scl_t(o_scl_t), .o_sda_t(o_sda_t),
    .i_scl_pad(i_scl_pad), .i_sda_pad(i_sda_pad),
    .o_scl_filt(o_scl_filt), .o_sda_filt(o_sda_filt),
    .o_start_det(o_start_det), .o_stop_det(o_stop_det),
    .o_busy(o_busy), .o_stretch(o_stretch), .o_arb_lost(o_arb_lost)
  );

  // ---------------- reference model ----------------
  // Pad history is kept as a list of samples (newest first); a line's
  // filtered level flips once the FL samples seen through the two-stage
  // synchroniser all disagree with it.
  bit m_scl_t, m_sda_t, m_intent;
  bit m_scl_f, m_sda_f, m_scl_p, m_sda_p;
  bit m_busy, m_arb;
  int m_idle, m_rel;
  bit q_scl[$];
  bit q_sda[$];

  task automatic model_reset();
    m_scl_t = 1; m_sda_t = 1; m_intent = 0;
    m_scl_f = 1; m_sda_f = 1; m_scl_p = 1; m_sda_p = 1;
    m_busy = 0; m_arb = 0; m_idle = 0; m_rel = 0;
    q_scl.delete(); q_sda.delete();
    for (int i = 0; i < FL + 2; i++) begin
      q_scl.push_back(1'b1);
      q_sda.push_back(1'b1);
    end
  endtask

  task automatic model_edge(input bit scl_pad, input bit sda_pad, input bit a_scl,
                            input bit a_sda, input bit a_dir, input bit a_clr);
    bit start, stop, rise, timeout, flip_scl, flip_sda, n_busy, n_arb;
    int n_idle, n_rel;
    start   = m_scl_p && m_scl_f && m_sda_p && !m_sda_f;
    stop    = m_scl_p && m_scl_f && !m_sda_p && m_sda_f;
    rise    = !m_scl_p && m_scl_f;
    timeout = (m_idle == IT);

    q_scl.push_front(scl_pad); void'(q_scl.pop_back());
    q_sda.push_front(sda_pad); void'(q_sda.pop_back());
    flip_scl = 1; flip_sda = 1;
    for (int i = 2; i < FL + 2; i++) begin
      if (q_scl[i] == m_scl_f) flip_scl = 0;
      if (q_sda[i] == m_sda_f) flip_sda = 0;
    end

    if ((m_scl_f != m_scl_p) || (m_sda_f != m_sda_p) || !(m_scl_f && m_sda_f)) n_idle = 0;
    else n_idle = (m_idle < IT) ? m_idle + 1 : m_idle;

    n_busy = start ? 1'b1 : ((stop || timeout) ? 1'b0 : m_busy);

    if (!m_scl_t || m_scl_f) n_rel = 0;
    else n_rel = (m_rel < 31) ? m_rel + 1 : 31;

    if (rise && m_intent && !m_sda_f && m_busy) n_arb = 1;
    else if (a_clr) n_arb = 0;
    else n_arb = m_arb;

    m_scl_p = m_scl_f; m_sda_p = m_sda_f;
    if (flip_scl) m_scl_f = !m_scl_f;
    if (flip_sda) m_sda_f = !m_sda_f;
    m_idle = n_idle; m_busy = n_busy; m_rel = n_rel; m_arb = n_arb;
    m_scl_t = a_scl; m_sda_t = a_dir | a_sda; m_intent = !a_dir && a_sda;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("scl_t", o_scl_t, m_scl_t);
    chk("sda_t", o_sda_t, m_sda_t);
    chk("scl_filt", o_scl_filt, m_scl_f);
    chk("sda_filt", o_sda_filt, m_sda_f);
    chk("start_det", o_start_det, m_scl_p && m_scl_f && m_sda_p && !m_sda_f);
    chk("stop_det", o_stop_det, m_scl_p && m_scl_f && !m_sda_p && m_sda_f);
    chk("busy", o_busy, m_busy);
    chk("stretch", o_stretch, (m_rel > FL + 3) && !m_scl_f);
    chk("arb_lost", o_arb_lost, m_arb);
  endtask

  // One clock: model advances on the same edge as the DUT, compare 1ns later.
  task automatic step();
    bit sp, dp, a_rst;
    bit a_scl, a_sda, a_dir, a_clr;
    sp = m_scl_t & ~ext_scl;
    dp = m_sda_t & ~ext_sda;
    a_rst = i_rst; a_scl = i_scl; a_sda = i_sda; a_dir = i_sda_dir; a_clr = i_clr_arb;
    @(posedge i_clk);
    if (a_rst) model_reset();
    else model_edge(sp, dp, a_scl, a_sda, a_dir, a_clr);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int n_ev, at, rise_at, fall_at, hold;
    bit prev_stretch, found;

    i_rst = 1; i_scl = 1; i_sda = 1; i_sda_dir = 1; i_clr_arb = 0;
    ext_scl = 0; ext_sda = 0;
    model_reset();

    // Reset state
    steps(3);
    chk("rst_scl_t", o_scl_t, 1'b1);
    chk("rst_sda_t", o_sda_t, 1'b1);
    chk("rst_scl_filt", o_scl_filt, 1'b1);
    chk("rst_sda_filt", o_sda_filt, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    i_rst = 0;
    steps(4);

    // Async reset while master drives SDA low
    i_sda_dir = 0; i_sda = 0; i_scl = 0;
    steps(3);
    chk("pre_rst_sda_t", o_sda_t, 1'b0);
    #2 i_rst = 1;
    model_reset();
    #1;
    chk("async_rst_sda_t", o_sda_t, 1'b1);
    chk("async_rst_scl_t", o_scl_t, 1'b1);
    @(posedge i_clk); #1;
    check_all();
    i_scl = 1; i_sda = 1; i_sda_dir = 1;
    step();
    i_rst = 0;
    steps(10);

    // Loopback START then STOP
    i_sda_dir = 0; i_sda = 0;
    n_ev = 0; at = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (o_start_det) begin n_ev++; at = k; end
    end
    chk_int("start_count", n_ev, 1);
    chk_int("start_latency", at, 1 + 2 + FL);
    chk("busy_after_start", o_busy, 1'b1);
    i_sda = 1;
    n_ev = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (o_stop_det) n_ev++;
    end
    chk_int("stop_count", n_ev, 1);
    chk("busy_after_stop", o_busy, 1'b0);

    // SDA pad glitches while SCL is high
    i_sda_dir = 1;
    steps(4);
    ext_sda = 1; steps(FL - 1); ext_sda = 0;
    n_ev = 0; found = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (o_start_det) n_ev++;
      if (!o_sda_filt) found = 1;
    end
    chk_int("glitch_start", n_ev, 0);
    chk("glitch_filt_low_seen", found, 1'b0);
    ext_sda = 1; steps(FL); ext_sda = 0;
    n_ev = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (o_start_det) n_ev++;
    end
    chk_int("accepted_start", n_ev, 1);
    steps(5);

    // Clock stretch
    i_scl = 0; steps(12);
    i_scl = 1; ext_scl = 1;
    at = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (o_stretch && at < 0) at = k;
    end
    chk_int("stretch_rise", at, FL + 5);
    ext_scl = 0;
    found = 0; prev_stretch = o_stretch;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (o_scl_filt) begin
        found = 1;
        chk("stretch_before_release", prev_stretch, 1'b1);
        chk("stretch_fall", o_stretch, 1'b0);
      end
      prev_stretch = o_stretch;
    end
    chk("stretch_scl_returned", found, 1'b1);
    steps(4);

    // Arbitration lost: master outputs 1, external driver holds SDA low
    i_sda_dir = 0; i_sda = 0; steps(12);
    i_scl = 0; steps(12);
    i_sda = 1; ext_sda = 1; steps(12);
    i_scl = 1; steps(12);
    chk("arb_set", o_arb_lost, 1'b1);
    steps(20);
    chk("arb_sticky", o_arb_lost, 1'b1);
    i_clr_arb = 1; step(); i_clr_arb = 0;
    steps(2);
    chk("arb_cleared", o_arb_lost, 1'b0);
    // Same pattern during an ACK slot (direction = input)
    i_scl = 0; steps(12);
    i_sda_dir = 1; steps(4);
    i_scl = 1; steps(12);
    chk("arb_ack_slot", o_arb_lost, 1'b0);
    ext_sda = 0; steps(12);
    chk("arb_busy_end", o_busy, 1'b0);

    // Idle timeout without STOP
    i_sda_dir = 0; i_sda = 0; steps(12);
    i_scl = 0; steps(12);
    i_sda = 1; steps(12);
    i_scl = 1;
    rise_at = -1; fall_at = -1;
    for (int k = 1; k <= IT + 100 && fall_at < 0; k++) begin
      step();
      if (o_scl_filt && rise_at < 0) rise_at = k;
      if (rise_at >= 0 && !o_busy) fall_at = k;
    end
    chk("timeout_busy_cleared", o_busy, 1'b0);
    chk_int("timeout_cycles", fall_at - rise_at, IT + 2);

    // Repeated START landing on the timeout cycle
    i_sda = 0; steps(12);
    i_scl = 0; steps(12);
    i_sda = 1; steps(12);
    i_scl = 1;
    found = 0;
    for (int k = 0; k < IT + 200 && !found; k++) begin
      step();
      if (m_idle == IT - 7) found = 1;
    end
    chk("coincide_reached", found, 1'b1);
    i_sda = 0;
    steps(8);
    chk("coincide_busy", o_busy, 1'b1);
    steps(20);
    chk("coincide_busy_hold", o_busy, 1'b1);
    i_sda = 1; steps(12);
    chk("coincide_stop", o_busy, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 2500; n += hold) begin
      hold = $urandom_range(1, 12);
      i_scl = 1'($urandom_range(0, 1));
      i_sda = 1'($urandom_range(0, 1));
      i_sda_dir = 1'($urandom_range(0, 1));
      ext_scl = ($urandom_range(0, 7) == 0);
      ext_sda = ($urandom_range(0, 7) == 0);
      i_clr_arb = ($urandom_range(0, 7) == 0);
      steps(hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
